mac_array_sequencer: RTL and testbench
======================================

MAC_ARRAY_SEQUENCER -- requirements
Module: mac_array_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: zero-feed cycles after the last operand, 1..15.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port wr_en, input, 1: operand buffer write strobe.
REQ-006 SHALL have port wr_sel, input, 1: 0 = A tile, 1 = B tile.
REQ-007 SHALL have port wr_addr, input, 4: element index, row*4+col.
REQ-008 SHALL have port wr_data, input, DATA_W: element value.
REQ-009 SHALL have port start, input, 1: one-cycle request to run a 4x4 tile product.
REQ-010 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when array results are final.
REQ-012 SHALL have port arr_clr, output, 1: one-cycle clear of the array accumulators.
REQ-013 SHALL have ports arr_a0..arr_a3, output, DATA_W each: row operands to the MAC array.
REQ-014 SHALL have ports arr_b0..arr_b3, output, DATA_W each: column operands to the MAC array.

Function
REQ-015 SHALL hold two 4x4 DATA_W buffers, A[r][c] and B[r][c].
REQ-016 SHALL write buffer (wr_sel, wr_addr) with wr_data on a clk edge with wr_en=1 only while busy=0; writes while busy=1 SHALL be dropped.
REQ-017 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-018 SHALL leave IDLE only on a start=1 edge; start in any other state SHALL be ignored, with no queuing.
REQ-019 SHALL assert busy in CLEAR, FEED and DRAIN, and deassert busy in DONE.
REQ-020 SHALL spend exactly 1 cycle in CLEAR with arr_clr=1; arr_clr SHALL be 0 in every other state.
REQ-021 SHALL spend exactly 7 cycles in FEED, counted by t = 0..6 on a 3-bit counter.
REQ-022 In FEED, arr_a[i] SHALL equal A[i][t-i] when 0 <= t-i <= 3, else 0 (skew of i cycles).
REQ-023 In FEED, arr_b[j] SHALL equal B[t-j][j] when 0 <= t-j <= 3, else 0 (skew of j cycles).
REQ-024 SHALL spend exactly DRAIN_CYCLES cycles in DRAIN with all arr_a/arr_b = 0.
REQ-025 SHALL spend 1 cycle in DONE with done=1, then return to IDLE.
REQ-026 All outputs SHALL be registered; arr_a/arr_b SHALL be 0 in IDLE, CLEAR and DONE.
REQ-027 Latency: for start sampled at edge N, arr_clr SHALL be high in cycle N+1, FEED SHALL occupy N+2..N+8, and done SHALL be high in cycle N+9+DRAIN_CYCLES.
REQ-028 start asserted in the DONE cycle SHALL be ignored; start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a minimum start-to-start spacing of 10+DRAIN_CYCLES cycles.
REQ-029 SHALL not compute arithmetic; operands SHALL pass unmodified at DATA_W.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, busy=0, done=0, arr_clr=0, all arr_a/arr_b=0, t=0, and both buffers to all zeros.
REQ-031 Reset during any non-IDLE state SHALL abort the run with no done pulse.
REQ-032 Release SHALL take effect on the first clk edge with reset=1, with no extra wait cycles.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, the tile dimension constant (4), and FEED_LEN = 7.
REQ-034 SHALL be a single module; the skew mux MAY be a sub-module operand_skew.
REQ-035 SHALL connect directly to the 4x4 MAC array operand inputs; arr_clr SHALL drive the array's accumulator clear.

Verification
REQ-036 Identity run: load A=I and B[r][c]=r*4+c+1, then pulse start -> arr_b0 SHALL read 1,5,9,13 in FEED cycles t=0..3, arr_a3 SHALL read 1 at t=6, and done SHALL be high in cycle N+13 with DRAIN_CYCLES=4.
REQ-037 Busy write: during FEED, write wr_sel=0, wr_addr=0, data 0xFF -> the value SHALL be dropped, and the next run SHALL stream the old A[0][0].
REQ-038 Start while busy: pulse start again in FEED -> no restart occurs and exactly one done pulse is produced.
REQ-039 Mid-run reset: assert reset=0 at FEED t=3 -> all outputs SHALL read 0 immediately, no done pulse SHALL occur, and buffers SHALL read zero on the next run.
REQ-040 Back-to-back: start in the DONE cycle -> ignored; start one cycle later -> accepted, with arr_clr high in the following cycle.
REQ-041 End-to-end with the array: random signed-free A and B tiles -> after done, the array outputs SHALL match the reference model of the array's accumulation over the streamed operands.

Source files
------------

// File: rtl/mac_array_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mac_array_sequencer_pkg : shared FSM states and tile geometry for the
//                           4x4 MAC array operand sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_array_sequencer_pkg;

  localparam int TILE     = 4;
  localparam int FEED_LEN = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mac_array_sequencer_operand_skew.sv
// ----------------------------------------------------------------------------
// mac_array_sequencer_operand_skew : selects the diagonal wavefront of A and B
//                                   elements for feed step t.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_array_sequencer_operand_skew
  import mac_array_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        t_i,
  input  logic [DATA_W-1:0] a_buf_i [TILE][TILE],
  input  logic [DATA_W-1:0] b_buf_i [TILE][TILE],
  output logic [DATA_W-1:0] a_o     [TILE],
  output logic [DATA_W-1:0] b_o     [TILE]
);

  // Row i / column j lags by i / j steps: element k is presented when t == i+k.
  always_comb begin
    for (int i = 0; i < TILE; i++) begin
      a_o[i] = '0;
      b_o[i] = '0;
      for (int k = 0; k < TILE; k++) begin
        if (int'(t_i) == i + k) begin
          a_o[i] = a_buf_i[i][k];
          b_o[i] = b_buf_i[k][i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_array_sequencer.sv
// ----------------------------------------------------------------------------
// mac_array_sequencer : buffers A/B tiles and streams them, skewed, into a
//                       4x4 systolic MAC array.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_array_sequencer
  import mac_array_sequencer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              arr_clr,
  output logic [DATA_W-1:0] arr_a0,
  output logic [DATA_W-1:0] arr_a1,
  output logic [DATA_W-1:0] arr_a2,
  output logic [DATA_W-1:0] arr_a3,
  output logic [DATA_W-1:0] arr_b0,
  output logic [DATA_W-1:0] arr_b1,
  output logic [DATA_W-1:0] arr_b2,
  output logic [DATA_W-1:0] arr_b3
);

  state_e            state_q, state_d;
  logic [2:0]        t_q, t_d;
  logic [3:0]        drain_q, drain_d;
  logic [DATA_W-1:0] a_buf_q [TILE][TILE];
  logic [DATA_W-1:0] b_buf_q [TILE][TILE];
  logic              busy_q, done_q, clr_q;
  logic [DATA_W-1:0] arr_a_q [TILE];
  logic [DATA_W-1:0] arr_b_q [TILE];
  logic [DATA_W-1:0] skew_a_w [TILE];
  logic [DATA_W-1:0] skew_b_w [TILE];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = 3'd0;
      end
      ST_FEED: begin
        if (t_q == 3'(FEED_LEN - 1)) begin
          state_d = ST_DRAIN;
          t_d     = 3'd0;
          drain_d = 4'd0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
        else                                 drain_d = drain_q + 4'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Skew is evaluated on the next feed step so the operand registers line up with the state.
  mac_array_sequencer_operand_skew #(
    .DATA_W (DATA_W)
  ) u_skew (
    .t_i     (t_d),
    .a_buf_i (a_buf_q),
    .b_buf_i (b_buf_q),
    .a_o     (skew_a_w),
    .b_o     (skew_b_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      t_q     <= 3'd0;
      drain_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      for (int i = 0; i < TILE; i++) begin
        arr_a_q[i] <= '0;
        arr_b_q[i] <= '0;
        for (int k = 0; k < TILE; k++) begin
          a_buf_q[i][k] <= '0;
          b_buf_q[i][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      busy_q  <= (state_d == ST_CLEAR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
      clr_q   <= (state_d == ST_CLEAR);
      for (int i = 0; i < TILE; i++) begin
        arr_a_q[i] <= (state_d == ST_FEED) ? skew_a_w[i] : '0;
        arr_b_q[i] <= (state_d == ST_FEED) ? skew_b_w[i] : '0;
      end
      if (wr_en && !busy_q) begin
        if (wr_sel) b_buf_q[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
        else        a_buf_q[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign arr_clr = clr_q;
  assign arr_a0  = arr_a_q[0];
  assign arr_a1  = arr_a_q[1];
  assign arr_a2  = arr_a_q[2];
  assign arr_a3  = arr_a_q[3];
  assign arr_b0  = arr_b_q[0];
  assign arr_b1  = arr_b_q[1];
  assign arr_b2  = arr_b_q[2];
  assign arr_b3  = arr_b_q[3];

endmodule

`default_nettype wire

// File: tb/tb_mac_array_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_array_sequencer : randomized self-checking bench with a tile-level
//                          reference model and a systolic accumulation model.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_array_sequencer;

  localparam int DW    = 8;
  localparam int DRAIN = 4;
  localparam int LEN   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, arr_clr;
  logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;

  mac_array_sequencer #(.DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .arr_clr (arr_clr),
    .arr_a0  (a0),
    .arr_a1  (a1),
    .arr_a2  (a2),
    .arr_a3  (a3),
    .arr_b0  (b0),
    .arr_b1  (b1),
    .arr_b2  (b2),
    .arr_b3  (b3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];

  logic [66:0]   cap_vec [64];
  logic [DW-1:0] cap_a   [64][4];
  logic [DW-1:0] cap_b   [64][4];

  function automatic logic [66:0] now_vec();
    return {busy, done, arr_clr, a0, a1, a2, a3, b0, b1, b2, b3};
  endfunction

  // Tile-level expectation for cycle c after the start-sampling edge.
  function automatic logic [DW-1:0] exp_a(int c, int i);
    int k;
    k = (c - 2) - i;
    if (c >= 2 && c <= 8 && k >= 0 && k <= 3) return ma[i][k];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_b(int c, int j);
    int k;
    k = (c - 2) - j;
    if (c >= 2 && c <= 8 && k >= 0 && k <= 3) return mb[k][j];
    return '0;
  endfunction

  function automatic logic [66:0] exp_vec(int c);
    logic eb, ed, ec;
    eb = (c >= 1) && (c <= 8 + DRAIN);
    ed = (c == 9 + DRAIN);
    ec = (c == 1);
    return {eb, ed, ec, exp_a(c,0), exp_a(c,1), exp_a(c,2), exp_a(c,3),
            exp_b(c,0), exp_b(c,1), exp_b(c,2), exp_b(c,3)};
  endfunction

  task automatic write_elem(input logic sel, input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    if (sel) mb[addr/4][addr%4] = data;
    else     ma[addr/4][addr%4] = data;
  endtask

  // Pulses start, then records outputs for cycles 1..n; optional busy write / extra starts.
  task automatic run_capture(input int n, input int wr_at, input logic [63:0] start_mask);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_vec[c] = now_vec();
      cap_a[c][0] = a0; cap_a[c][1] = a1; cap_a[c][2] = a2; cap_a[c][3] = a3;
      cap_b[c][0] = b0; cap_b[c][1] = b1; cap_b[c][2] = b2; cap_b[c][3] = b3;
      start   = start_mask[c];
      wr_en   = (c == wr_at);
      wr_sel  = 1'b0;
      wr_addr = 4'd0;
      wr_data = 8'hFF;
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (now_vec() !== 67'd0) $display("FAIL reset_hold: got %h want 0", now_vec());
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    write_elem(1'b0, 0, 8'h55);
    write_elem(1'b1, 5, 8'h66);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (now_vec() !== 67'd0) $display("FAIL reset_async: got %h want 0", now_vec());
    else passes++;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    @(negedge clk);
    reset = 1'b1;
    run_capture(LEN, 0, 64'd0);
    for (int c = 1; c <= LEN; c++) begin
      checks++;
      if (cap_vec[c] !== exp_vec(c)) $display("FAIL reset_run c=%0d: got %h want %h", c, cap_vec[c], exp_vec(c));
      else passes++;
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r*4+c, (r == c) ? 8'd1 : 8'd0);
        write_elem(1'b1, r*4+c, 8'(r*4+c+1));
      end
    run_capture(LEN, 0, 64'd0);
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (cap_b[t+2][0] !== 8'(t*4+1)) $display("FAIL ident_b0 t=%0d: got %0d want %0d", t, cap_b[t+2][0], t*4+1);
      else passes++;
    end
    checks++;
    if (cap_a[8][3] !== 8'd1) $display("FAIL ident_a3_t6: got %0d want 1", cap_a[8][3]);
    else passes++;
    checks++;
    if (cap_vec[13][65] !== 1'b1) $display("FAIL ident_done_n13: got %b want 1", cap_vec[13][65]);
    else passes++;
    for (int c = 1; c <= LEN; c++) begin
      checks++;
      if (cap_vec[c] !== exp_vec(c)) $display("FAIL ident_run c=%0d: got %h want %h", c, cap_vec[c], exp_vec(c));
      else passes++;
    end
  endtask

  task automatic test_busy_write();
    logic [DW-1:0] old00;
    old00 = ma[0][0];
    run_capture(LEN, 4, 64'd0);
    for (int c = 1; c <= LEN; c++) begin
      checks++;
      if (cap_vec[c] !== exp_vec(c)) $display("FAIL busywr_run c=%0d: got %h want %h", c, cap_vec[c], exp_vec(c));
      else passes++;
    end
    run_capture(LEN, 0, 64'd0);
    checks++;
    if (cap_a[2][0] !== old00) $display("FAIL busywr_a00: got %h want %h", cap_a[2][0], old00);
    else passes++;
  endtask

  task automatic test_start_while_busy();
    int ndone, nclr;
    logic [63:0] m;
    m = 64'd0;
    m[5] = 1'b1;
    run_capture(30, 0, m);
    ndone = 0;
    nclr  = 0;
    for (int c = 1; c <= 30; c++) begin
      if (cap_vec[c][65]) ndone++;
      if (cap_vec[c][64]) nclr++;
    end
    checks++;
    if (ndone !== 1) $display("FAIL swb_done_count: got %0d want 1", ndone);
    else passes++;
    checks++;
    if (nclr !== 1) $display("FAIL swb_clr_count: got %0d want 1", nclr);
    else passes++;
    checks++;
    if (cap_vec[13][65] !== 1'b1) $display("FAIL swb_done_n13: got %b want 1", cap_vec[13][65]);
    else passes++;
  endtask

  task automatic test_mid_reset();
    int ndone;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_pre: got %b want 1", busy);
    else passes++;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (now_vec() !== 67'd0) $display("FAIL midrst_zero: got %h want 0", now_vec());
    else passes++;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("FAIL midrst_no_done: got %0d want 0", ndone);
    else passes++;
    run_capture(LEN, 0, 64'd0);
    for (int c = 1; c <= LEN; c++) begin
      checks++;
      if (cap_vec[c] !== exp_vec(c)) $display("FAIL midrst_rerun c=%0d: got %h want %h", c, cap_vec[c], exp_vec(c));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m;
    int ndone;
    for (int k = 0; k < 32; k++) write_elem(k[4], k % 16, 8'($urandom_range(0, 255)));
    m = 64'd0;
    m[9+DRAIN]  = 1'b1;
    m[10+DRAIN] = 1'b1;
    run_capture(30, 0, m);
    checks++;
    if (cap_vec[14][64] !== 1'b0) $display("FAIL b2b_clr_after_done: got %b want 0", cap_vec[14][64]);
    else passes++;
    checks++;
    if (cap_vec[14][66] !== 1'b0) $display("FAIL b2b_busy_idle: got %b want 0", cap_vec[14][66]);
    else passes++;
    checks++;
    if (cap_vec[15][64] !== 1'b1) $display("FAIL b2b_clr_accept: got %b want 1", cap_vec[15][64]);
    else passes++;
    ndone = 0;
    for (int c = 1; c <= 30; c++) if (cap_vec[c][65]) ndone++;
    checks++;
    if (ndone !== 2 || cap_vec[27][65] !== 1'b1) $display("FAIL b2b_done: got count %0d at27 %b want 2 1", ndone, cap_vec[27][65]);
    else passes++;
    for (int c = 1; c <= LEN; c++) begin
      checks++;
      if (cap_vec[c+14] !== exp_vec(c)) $display("FAIL b2b_second c=%0d: got %h want %h", c, cap_vec[c+14], exp_vec(c));
      else passes++;
    end
  endtask

  task automatic test_random_tiles();
    int acc, ref_c, ta, tb;
    for (int iter = 0; iter < 3; iter++) begin
      for (int k = 0; k < 32; k++) write_elem(k[4], k % 16, 8'($urandom_range(0, 255)));
      run_capture(LEN, 0, 64'd0);
      for (int c = 1; c <= LEN; c++) begin
        checks++;
        if (cap_vec[c] !== exp_vec(c)) $display("FAIL rand_stream it=%0d c=%0d: got %h want %h", iter, c, cap_vec[c], exp_vec(c));
        else passes++;
      end
      // PE(i,j) sees row-i operand delayed j steps and column-j operand delayed i steps.
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc = 0;
          for (int t = 0; t <= 10; t++) begin
            ta = t - j;
            tb = t - i;
            if (ta >= 0 && tb >= 0)
              acc += int'(cap_a[ta+2][i]) * int'(cap_b[tb+2][j]);
          end
          ref_c = 0;
          for (int k = 0; k < 4; k++) ref_c += int'(ma[i][k]) * int'(mb[k][j]);
          checks++;
          if (acc !== ref_c) $display("FAIL rand_array it=%0d C[%0d][%0d]: got %0d want %0d", iter, i, j, acc, ref_c);
          else passes++;
        end
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = 4'd0;
    wr_data = '0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_busy_write();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    test_random_tiles();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
